param_memory: RTL and testbench

PARAM_MEMORY -- requirements
Module: param_memory

---
 rtl/param_memory_pkg.sv | 13 +
 rtl/param_memory_rd_pipe.sv | 70 +++++++
 rtl/param_memory.sv | 113 +++++++++++
 tb/tb_param_memory.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_memory_pkg.sv
// Shared definitions for the parameterised scratch memory: FSM state encoding
// and the range of supported read latencies.
package param_memory_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/param_memory_rd_pipe.sv
// Read-response pipeline: carries valid, data and error flags for RD_LAT cycles
// and merges the write-error strobe into the registered err output.
module param_memory_rd_pipe
    import param_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_err,
    input  logic              wr_err,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              err
);

    logic              last_valid_s;
    logic              last_err_s;
    logic [DATA_W-1:0] last_data_s;

    generate
        if (RD_LAT >= RD_LAT_MAX) begin : g_two_stage
            logic              mid_valid_r;
            logic              mid_err_r;
            logic [DATA_W-1:0] mid_data_r;

            // Intermediate stage for the two-cycle latency option.
            always_ff @(posedge clk) begin
                if (reset) begin
                    mid_valid_r <= 1'b0;
                    mid_err_r   <= 1'b0;
                    mid_data_r  <= {DATA_W{1'b0}};
                end else begin
                    mid_valid_r <= rd_valid;
                    mid_err_r   <= rd_valid & rd_err;
                    if (rd_valid) begin
                        mid_data_r <= rd_data;
                    end
                end
            end

            assign last_valid_s = mid_valid_r;
            assign last_err_s   = mid_err_r;
            assign last_data_s  = mid_data_r;
        end else begin : g_one_stage
            assign last_valid_s = rd_valid;
            assign last_err_s   = rd_valid & rd_err;
            assign last_data_s  = rd_data;
        end
    endgenerate

    // Output stage; read data only moves on a valid response so it holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            err       <= 1'b0;
        end else begin
            rsp_valid <= last_valid_s;
            err       <= last_err_s | wr_err;
            if (last_valid_s) begin
                rsp_rdata <= last_data_s;
            end
        end
    end

endmodule

// File: rtl/param_memory.sv
// Byte-writable scratch memory with a zeroing sweep after reset and a
// configurable-latency read path.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                err,
    output logic                init_busy
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] sweep_cnt_r;
    logic              init_busy_r;
    logic              req_ready_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              fire_s;
    logic              in_range_s;
    logic              wr_fire_s;
    logic              wr_err_s;
    logic              rd_fire_s;
    logic [DATA_W-1:0] rd_data_s;

    // Zero-extend before comparing so an address past DEPTH can never alias.
    assign in_range_s = ({1'b0, req_addr} < DEPTH_EXT);
    assign fire_s     = req_valid & req_ready_r & ~reset;
    assign wr_fire_s  = fire_s & req_wr & in_range_s;
    assign wr_err_s   = fire_s & req_wr & ~in_range_s;
    assign rd_fire_s  = fire_s & ~req_wr;
    assign rd_data_s  = in_range_s ? mem_r[req_addr] : {DATA_W{1'b0}};

    // Next-state logic: the sweep leaves INIT once the last word is cleared.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (sweep_cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State, sweep counter and the registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_INIT;
            sweep_cnt_r <= {ADDR_W{1'b0}};
            init_busy_r <= 1'b1;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sweep_cnt_r <= (state_r == ST_INIT) ? sweep_cnt_r + ADDR_W'(1) : sweep_cnt_r;
            init_busy_r <= (state_nxt_s == ST_INIT);
            req_ready_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Storage: sweep clears one word per cycle, otherwise byte-masked writes.
    always_ff @(posedge clk) begin
        if (!reset && (state_r == ST_INIT)) begin
            mem_r[sweep_cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_fire_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_r[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    param_memory_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_valid  (rd_fire_s),
        .rd_data   (rd_data_s),
        .rd_err    (~in_range_s),
        .wr_err    (wr_err_s),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .err       (err)
    );

    assign init_busy = init_busy_r;
    assign req_ready = req_ready_r;

endmodule

// File: tb/tb_param_memory.sv
// Drives two param_memory configurations with shared stimulus and checks each
// against a queue-based reference model of the memory's observable behaviour.
module tb_param_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_wr = 1'b0;
    logic [3:0]  req_addr = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;

    logic        a_req_ready, a_rsp_valid, a_err, a_init_busy;
    logic [7:0]  a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_err, b_init_busy;
    logic [31:0] b_rsp_rdata;

    always #5 clk = ~clk;

    // dut_a: defaults (8-bit, 16 words, latency 1)
    param_memory u_dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata[7:0]), .req_be(req_be[0:0]),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .err(a_err), .init_busy(a_init_busy)
    );

    // dut_b: 32-bit, 12 words in a 4-bit address space, latency 2
    param_memory #(.DATA_W(32), .DEPTH(12), .ADDR_W(4), .RD_LAT(2)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .err(b_err), .init_busy(b_init_busy)
    );

    logic [11:0] act_a, exp_a;
    logic [35:0] act_b, exp_b;
    assign act_a = {a_rsp_valid, a_err, a_init_busy, a_req_ready, a_rsp_rdata};
    assign act_b = {b_rsp_valid, b_err, b_init_busy, b_req_ready, b_rsp_rdata};

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: per-DUT memory image, remaining sweep cycles, pending output events.
    typedef struct {
        int          d;
        int          due;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] mem_m [2][16];
    int          busy_m [2];
    logic [31:0] hold_m [2];

    task automatic step(input logic v, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic rst);
        ev_t  keep[$];
        bit   val_e [2];
        bit   err_e [2];
        int   dep, lat, nby;
        req_valid = v; req_wr = wr; req_addr = addr; req_wdata = wd; req_be = be; reset = rst;
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            dep = (d == 0) ? 16 : 12;
            lat = (d == 0) ? 1 : 2;
            nby = (d == 0) ? 1 : 4;
            val_e[d] = 1'b0;
            err_e[d] = 1'b0;
            if (rst) begin
                busy_m[d] = dep;
                hold_m[d] = 32'd0;
                for (int i = 0; i < 16; i++) mem_m[d][i] = 32'd0;
            end else begin
                if (v && busy_m[d] == 0) begin
                    if (wr) begin
                        if (int'(addr) < dep) begin
                            for (int b = 0; b < nby; b++)
                                if (be[b]) mem_m[d][addr][b*8 +: 8] = wd[b*8 +: 8];
                        end else begin
                            evq.push_back('{d: d, due: cyc, is_rd: 1'b0, data: 32'd0, err: 1'b1});
                        end
                    end else begin
                        evq.push_back('{d: d, due: cyc + lat - 1, is_rd: 1'b1,
                                        data: (int'(addr) < dep) ? mem_m[d][addr] : 32'd0,
                                        err: (int'(addr) >= dep)});
                    end
                end
                if (busy_m[d] > 0) busy_m[d]--;
            end
        end
        if (rst) evq.delete();
        foreach (evq[i]) begin
            if (evq[i].due == cyc) begin
                if (evq[i].is_rd) begin
                    val_e[evq[i].d] = 1'b1;
                    hold_m[evq[i].d] = evq[i].data;
                end
                if (evq[i].err) err_e[evq[i].d] = 1'b1;
            end else begin
                keep.push_back(evq[i]);
            end
        end
        evq = keep;
        exp_a = {val_e[0], err_e[0], busy_m[0] > 0, busy_m[0] == 0, hold_m[0][7:0]};
        exp_b = {val_e[1], err_e[1], busy_m[1] > 0, busy_m[1] == 0, hold_m[1]};
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        if (act_a !== 12'h200) begin failures++; $display("FAIL reset_a got=%h exp=%h", act_a, 12'h200); end
        if (act_b !== {4'b0010, 32'd0}) begin failures++; $display("FAIL reset_b got=%h exp=%h", act_b, {4'b0010, 32'd0}); end
        checks += 2;
    endtask

    task automatic test_init_sweep;
        int na, nb, nrsp;
        na = 1; nb = 1; nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
            na += a_init_busy;
            nb += b_init_busy;
            if (act_a !== exp_a) begin failures++; $display("FAIL sweep_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL sweep_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
        if (na !== 16) begin failures++; $display("FAIL busy_len_a got=%0d exp=16", na); end
        if (nb !== 12) begin failures++; $display("FAIL busy_len_b got=%0d exp=12", nb); end
        checks += 2;
        for (int i = 0; i < 18; i++) begin
            step(i < 16, 1'b0, 4'(i), 32'd0, 4'd0, 1'b0);
            if (a_rsp_valid) nrsp++;
            if (act_a !== exp_a) begin failures++; $display("FAIL zero_rd_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL zero_rd_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
        if (nrsp !== 16) begin failures++; $display("FAIL zero_rd_cnt got=%0d exp=16", nrsp); end
        checks++;
    endtask

    task automatic test_byte_enables;
        int seen;
        seen = 0;
        step(1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0);
        step(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 1'b0, 4'd3, 32'd0, 4'd0, 1'b0);
            if (b_rsp_valid) begin
                seen++;
                if (b_rsp_rdata !== 32'hAA22CC44) begin failures++; $display("FAIL be_data got=%h exp=%h", b_rsp_rdata, 32'hAA22CC44); end
                checks++;
            end
            if (act_a !== exp_a) begin failures++; $display("FAIL be_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL be_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
        if (seen !== 1) begin failures++; $display("FAIL be_rsp_cnt got=%0d exp=1", seen); end
        checks++;
    endtask

    task automatic test_back_to_back;
        logic [6:0] pat;
        step(1'b1, 1'b1, 4'd7, 32'h0000005A, 4'b1111, 1'b0);
        step(1'b1, 1'b0, 4'd7, 32'd0, 4'd0, 1'b0);
        if ({b_rsp_valid, a_rsp_valid, a_rsp_rdata} !== {1'b0, 1'b1, 8'h5A}) begin
            failures++; $display("FAIL lat_first got=%b%b/%h exp=01/5a", b_rsp_valid, a_rsp_valid, a_rsp_rdata);
        end
        checks++;
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        if ({b_rsp_valid, b_rsp_rdata} !== {1'b1, 32'h5A}) begin
            failures++; $display("FAIL lat_second got=%b/%h exp=1/5a", b_rsp_valid, b_rsp_rdata);
        end
        checks++;
        for (int i = 0; i < 7; i++) begin
            step(i < 4, 1'b0, 4'(i), 32'd0, 4'd0, 1'b0);
            pat[6-i] = b_rsp_valid;
            if (act_a !== exp_a) begin failures++; $display("FAIL b2b_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL b2b_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
        if (pat !== 7'b0111100) begin failures++; $display("FAIL b2b_pattern got=%b exp=0111100", pat); end
        checks++;
    endtask

    task automatic test_out_of_range;
        step(1'b1, 1'b1, 4'd13, 32'hFFFFFFFF, 4'b1111, 1'b0);
        if ({b_err, a_err} !== 2'b10) begin failures++; $display("FAIL oor_wr_err got=%b exp=10", {b_err, a_err}); end
        checks++;
        step(1'b1, 1'b0, 4'd13, 32'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
        if ({b_rsp_valid, b_err, b_rsp_rdata} !== {2'b11, 32'd0}) begin
            failures++; $display("FAIL oor_rd got=%b%b/%h exp=11/0", b_rsp_valid, b_err, b_rsp_rdata);
        end
        checks++;
        for (int i = 0; i < 14; i++) begin
            step(i < 12, 1'b0, 4'(i), 32'd0, 4'd0, 1'b0);
            if (act_a !== exp_a) begin failures++; $display("FAIL oor_scan_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL oor_scan_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
    endtask

    task automatic test_reset_mid_read;
        int nb, nv;
        step(1'b1, 1'b1, 4'd5, 32'h3C3C3C3C, 4'b1111, 1'b0);
        step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1);
        nb = b_init_busy;
        nv = b_rsp_valid;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0);
            nb += b_init_busy;
            nv += b_rsp_valid;
        end
        if (nv !== 0) begin failures++; $display("FAIL rst_flush got=%0d exp=0", nv); end
        if (nb !== 12) begin failures++; $display("FAIL rst_busy_len got=%0d exp=12", nb); end
        checks += 2;
        for (int i = 0; i < 3; i++) begin
            step(i == 0, 1'b0, 4'd5, 32'd0, 4'd0, 1'b0);
            if (act_a !== exp_a) begin failures++; $display("FAIL rst_rd_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL rst_rd_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 149) == 0);
            if (act_a !== exp_a) begin failures++; $display("FAIL rand_a cyc=%0d got=%h exp=%h", cyc, act_a, exp_a); end
            if (act_b !== exp_b) begin failures++; $display("FAIL rand_b cyc=%0d got=%h exp=%h", cyc, act_b, exp_b); end
            checks += 2;
        end
    endtask

    initial begin
        test_reset;
        test_init_sweep;
        test_byte_enables;
        test_back_to_back;
        test_out_of_range;
        test_reset_mid_read;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
